// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID skid stage: the NOP instruction, the
// skid state encoding and the rs1/rs2 field positions in an instruction.
package pipe_pkg;

  // addi x0, x0, 0 : what decode sees whenever the stage holds nothing
  localparam logic [31:0] PIPE_NOP_INSN = 32'h0000_0013;

  // Occupancy of the stage: nothing, main entry only, main plus skid entry
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Register-index field positions inside an instruction word
  localparam int REG_IDX_W = 5;
  localparam int RS1_LSB   = 15;
  localparam int RS1_MSB   = 19;
  localparam int RS2_LSB   = 20;
  localparam int RS2_MSB   = 24;

endpackage

// File: rtl/if_id_skid_if.sv
// Fetch-to-decode handshake bundle for the IF/ID skid stage.
// The stage itself connects through the master modport; the fetch/decode
// environment connects through the slave modport.
interface if_id_skid_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int SB_W = 2
);

  // Fetch side
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [ILEN-1:0] in_insn;
  logic [SB_W-1:0] in_sb;

  // Decode side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_insn;
  logic [SB_W-1:0] out_sb;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;

  modport master (
    input  in_valid, in_pc, in_insn, in_sb, out_ready,
    output in_ready, out_valid, out_pc, out_insn, out_sb, out_rs1, out_rs2
  );

  modport slave (
    output in_valid, in_pc, in_insn, in_sb, out_ready,
    input  in_ready, out_valid, out_pc, out_insn, out_sb, out_rs1, out_rs2
  );

endinterface

// File: rtl/skid_entry.sv
// One valid+payload holding register of the IF/ID skid stage.
// clear wins over load; a cleared entry holds pc=0, insn=NOP, sb=0 so that
// nothing stale can ever leak towards decode.
module skid_entry #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              SB_W     = 2,
  parameter logic [ILEN-1:0] NOP_INSN = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            load,
  input  logic            d_valid,
  input  logic [XLEN-1:0] d_pc,
  input  logic [ILEN-1:0] d_insn,
  input  logic [SB_W-1:0] d_sb,
  output logic            q_valid,
  output logic [XLEN-1:0] q_pc,
  output logic [ILEN-1:0] q_insn,
  output logic [SB_W-1:0] q_sb
);

  // Entry register: async reset and synchronous clear both return it to the bubble value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_valid <= 1'b0;
      q_pc    <= '0;
      q_insn  <= NOP_INSN;
      q_sb    <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_pc    <= '0;
      q_insn  <= NOP_INSN;
      q_sb    <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      q_pc    <= d_pc;
      q_insn  <= d_insn;
      q_sb    <= d_sb;
    end
  end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// Fetch may push one entry ahead of a stalled decode; in_ready is a pure
// decode of the registered occupancy and never looks at out_ready.
// Flush empties the stage; a same-cycle fetch entry is dropped.
// Optional build macro IF_ID_SKID_PERF_EN adds saturating stall/flush counters.
module if_id_skid
  import pipe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              SB_W     = 2,
  parameter logic [ILEN-1:0] NOP_INSN = ILEN'(PIPE_NOP_INSN),
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  if_id_skid_if.master     bus
`ifdef IF_ID_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  if (ILEN < 25 || SB_W < 1 || XLEN < 1 || CNT_W < 1) begin : g_param_check
    $error("if_id_skid: ILEN must be >= 25, SB_W/XLEN/CNT_W must be >= 1");
  end

  skid_state_e     state_q;
  skid_state_e     state_d;

  logic            in_ready;
  logic            accept;
  logic            pop;

  logic            main_load;
  logic            main_clear;
  logic            main_from_skid;
  logic            skid_load;
  logic            skid_clear;

  logic            main_valid;
  logic [XLEN-1:0] main_pc;
  logic [ILEN-1:0] main_insn;
  logic [SB_W-1:0] main_sb;

  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [ILEN-1:0] skid_insn;
  logic [SB_W-1:0] skid_sb;

  logic            main_d_valid;
  logic [XLEN-1:0] main_d_pc;
  logic [ILEN-1:0] main_d_insn;
  logic [SB_W-1:0] main_d_sb;

  logic [ILEN-1:0] out_insn;

  assign in_ready = (state_q != FULL);
  assign accept   = bus.in_valid & in_ready;
  assign pop      = main_valid & bus.out_ready;

  // Occupancy register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and entry load/clear strobes; flush overrides everything
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;

    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_load = 1'b1;
          end else if (pop) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Main entry refills either from fetch or from the skid entry when draining FULL
  always_comb begin
    main_d_valid = 1'b1;
    main_d_pc    = bus.in_pc;
    main_d_insn  = bus.in_insn;
    main_d_sb    = bus.in_sb;
    if (main_from_skid) begin
      main_d_valid = skid_valid;
      main_d_pc    = skid_pc;
      main_d_insn  = skid_insn;
      main_d_sb    = skid_sb;
    end
  end

  skid_entry #(
    .XLEN     (XLEN),
    .ILEN     (ILEN),
    .SB_W     (SB_W),
    .NOP_INSN (NOP_INSN)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (main_clear),
    .load    (main_load),
    .d_valid (main_d_valid),
    .d_pc    (main_d_pc),
    .d_insn  (main_d_insn),
    .d_sb    (main_d_sb),
    .q_valid (main_valid),
    .q_pc    (main_pc),
    .q_insn  (main_insn),
    .q_sb    (main_sb)
  );

  skid_entry #(
    .XLEN     (XLEN),
    .ILEN     (ILEN),
    .SB_W     (SB_W),
    .NOP_INSN (NOP_INSN)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (skid_clear),
    .load    (skid_load),
    .d_valid (1'b1),
    .d_pc    (bus.in_pc),
    .d_insn  (bus.in_insn),
    .d_sb    (bus.in_sb),
    .q_valid (skid_valid),
    .q_pc    (skid_pc),
    .q_insn  (skid_insn),
    .q_sb    (skid_sb)
  );

  // Decode-side view: an empty stage always shows a clean NOP bubble
  always_comb begin
    bus.out_pc = '0;
    out_insn   = NOP_INSN;
    bus.out_sb = '0;
    if (main_valid) begin
      bus.out_pc = main_pc;
      out_insn   = main_insn;
      bus.out_sb = main_sb;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_valid;
  assign bus.out_insn  = out_insn;
  assign bus.out_rs1   = out_insn[RS1_MSB:RS1_LSB];
  assign bus.out_rs2   = out_insn[RS2_MSB:RS2_LSB];

`ifdef IF_ID_SKID_PERF_EN
  // Saturating counters: decode back-pressure cycles and flushes that kill a live entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (main_valid && !bus.out_ready && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
      if (flush && (state_q != EMPTY) && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid.
// The reference is a plain 2-deep FIFO queue; every negative clock edge the
// DUT outputs are compared with what that queue says decode should see.
// Directed literal checks pin the queue model to hand-computed values.
// Define IF_ID_SKID_PERF_EN to also check the perf counters.
module tb_if_id_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [1:0]  sb;
  } entry_t;

  logic clk;
  logic reset_n;
  logic flush;

  int n_vec;
  int n_miss;

  entry_t model_q[$];
  int     exp_stall;
  int     exp_flush;

  if_id_skid_if #(.XLEN(32), .ILEN(32), .SB_W(2)) bus ();

`ifdef IF_ID_SKID_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  if_id_skid #(
    .XLEN     (32),
    .ILEN     (32),
    .SB_W     (2),
    .NOP_INSN (32'h0000_0013),
    .CNT_W    (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
`ifdef IF_ID_SKID_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Queue model of the stage, advanced on each clock edge with the inputs seen there
  always @(posedge clk or negedge reset_n) begin
    int     sz;
    bit     take;
    entry_t e;
    if (!reset_n) begin
      model_q.delete();
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      sz = model_q.size();
      if (sz > 0 && !bus.out_ready) exp_stall++;
      if (flush && sz > 0) exp_flush++;
      if (flush) begin
        model_q.delete();
      end else begin
        take = bus.in_valid && (sz < 2);
        if (sz > 0 && bus.out_ready) void'(model_q.pop_front());
        if (take) begin
          e.pc   = bus.in_pc;
          e.insn = bus.in_insn;
          e.sb   = bus.in_sb;
          model_q.push_back(e);
        end
      end
    end
  end

  task automatic checkOutput();
    logic [31:0] e_pc;
    logic [31:0] e_insn;
    logic [1:0]  e_sb;
    logic        e_valid;
    logic        e_ready;
    e_valid = (model_q.size() > 0);
    e_ready = (model_q.size() < 2);
    e_pc    = 32'h0;
    e_insn  = NOP;
    e_sb    = 2'b00;
    if (e_valid) begin
      e_pc   = model_q[0].pc;
      e_insn = model_q[0].insn;
      e_sb   = model_q[0].sb;
    end
    cmp("model.in_ready",  32'(bus.in_ready),  32'(e_ready));
    cmp("model.out_valid", 32'(bus.out_valid), 32'(e_valid));
    cmp("model.out_pc",    bus.out_pc,         e_pc);
    cmp("model.out_insn",  bus.out_insn,       e_insn);
    cmp("model.out_sb",    32'(bus.out_sb),    32'(e_sb));
    cmp("model.out_rs1",   32'(bus.out_rs1),   32'(e_insn[19:15]));
    cmp("model.out_rs2",   32'(bus.out_rs2),   32'(e_insn[24:20]));
`ifdef IF_ID_SKID_PERF_EN
    cmp("model.perf_stall", perf_stall_cnt, 32'(exp_stall));
    cmp("model.perf_flush", perf_flush_cnt, 32'(exp_flush));
`endif
  endtask

  // Compare process: outputs are stable mid-cycle
  always @(negedge clk) checkOutput();

  // Drive one cycle of inputs, then return just after the edge that consumed them
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                               input logic [1:0] sb, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_insn   = insn;
    bus.in_sb     = sb;
    bus.out_ready = ordy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 2'bxx, ordy, 1'b0);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    n_vec         = 0;
    n_miss        = 0;
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_insn   = '0;
    bus.in_sb     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("[TB] reset state");
    cmp("rst.out_valid", 32'(bus.out_valid), 32'd0);
    cmp("rst.in_ready",  32'(bus.in_ready),  32'd1);
    cmp("rst.out_insn",  bus.out_insn,       NOP);
    cmp("rst.out_pc",    bus.out_pc,         32'h0);

    $display("[TB] single entry, 1-cycle latency");
    applyStimulus(1'b1, 32'h100, 32'h0050_0093, 2'b01, 1'b1, 1'b0);
    cmp("one.out_valid", 32'(bus.out_valid), 32'd1);
    cmp("one.out_pc",    bus.out_pc,         32'h100);
    cmp("one.out_rs1",   32'(bus.out_rs1),   32'd0);
    cmp("one.out_rs2",   32'(bus.out_rs2),   32'd5);
    cmp("one.out_sb",    32'(bus.out_sb),    32'd1);
    cmp("one.in_ready",  32'(bus.in_ready),  32'd1);
    idle(1'b1);
    cmp("drain.out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] stall and skid");
    applyStimulus(1'b1, 32'h200, 32'h0011_8193, 2'b10, 1'b0, 1'b0);
    cmp("stall1.in_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(1'b1, 32'h204, 32'h0022_0213, 2'b11, 1'b0, 1'b0);
    cmp("stall2.in_ready", 32'(bus.in_ready), 32'd0);
    cmp("stall2.out_pc",   bus.out_pc,        32'h200);
    applyStimulus(1'b1, 32'h2FC, 32'h0000_0013, 2'b00, 1'b0, 1'b0);
    cmp("stall3.in_ready", 32'(bus.in_ready), 32'd0);
    cmp("stall3.out_pc",   bus.out_pc,        32'h200);
    idle(1'b1);
    cmp("release1.out_pc",   bus.out_pc,        32'h204);
    cmp("release1.out_insn", bus.out_insn,      32'h0022_0213);
    cmp("release1.in_ready", 32'(bus.in_ready), 32'd1);
    idle(1'b1);
    cmp("release2.out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] flush while full");
    applyStimulus(1'b1, 32'h300, 32'h0000_0093, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h304, 32'h0000_0113, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h208, 32'h0000_0193, 2'b01, 1'b0, 1'b1);
    cmp("flush.out_valid", 32'(bus.out_valid), 32'd0);
    cmp("flush.out_insn",  bus.out_insn,       NOP);
    cmp("flush.in_ready",  32'(bus.in_ready),  32'd1);
    idle(1'b1);
    cmp("flush.no_208", 32'(bus.out_valid), 32'd0);

    $display("[TB] back-to-back stream");
    for (int i = 0; i < 16; i++) begin
      logic [31:0] ins;
      ins = 32'h0000_0013 | (32'(i) << 15) | (32'(i) << 20);
      applyStimulus(1'b1, 32'(i * 4), ins, 2'(i), 1'b1, 1'b0);
      cmp("stream.out_pc",   bus.out_pc,        32'(i * 4));
      cmp("stream.in_ready", 32'(bus.in_ready), 32'd1);
    end
    idle(1'b1);
    cmp("stream.end_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] async reset while full");
    applyStimulus(1'b1, 32'h400, 32'h0000_0093, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h404, 32'h0000_0113, 2'b10, 1'b0, 1'b0);
    cmp("full.in_ready", 32'(bus.in_ready), 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    cmp("arst.out_valid", 32'(bus.out_valid), 32'd0);
    cmp("arst.in_ready",  32'(bus.in_ready),  32'd1);
    cmp("arst.out_insn",  bus.out_insn,       NOP);
    cmp("arst.out_pc",    bus.out_pc,         32'h0);
    cmp("arst.out_sb",    32'(bus.out_sb),    32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, 32'h500, 32'h0070_8093, 2'b01, 1'b1, 1'b0);
    cmp("post_rst.out_valid", 32'(bus.out_valid), 32'd1);
    cmp("post_rst.out_pc",    bus.out_pc,         32'h500);
    cmp("post_rst.out_rs1",   32'(bus.out_rs1),   32'd1);
    idle(1'b1);

    $display("[TB] perf scenario");
    doReset();
    applyStimulus(1'b1, 32'hA00, 32'h0000_0093, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1);
    cmp("perf.out_valid", 32'(bus.out_valid), 32'd0);
`ifdef IF_ID_SKID_PERF_EN
    cmp("perf.stall_cnt", perf_stall_cnt, 32'd5);
    cmp("perf.flush_cnt", perf_flush_cnt, 32'd1);
`endif
    idle(1'b1);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
